sram_req_arbiter: RTL and testbench

//   Shares one sram-like memory port (req/addr_ok/data_ok) between the IF-stage instruction

---
 rtl/sram_req_arbiter.sv | 144 ++++++++++++++
 tb/tb_sram_req_arbiter.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_req_arbiter.sv
// Arbitrates one sram-like port between instruction fetch and load/store traffic.
// Each accepted request gets an owner tag in an in-order FIFO; the tag steers the response back.
module sram_req_arbiter #(
    parameter int unsigned MAX_OUTST = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned PTR_W = $clog2(MAX_OUTST);
    localparam int unsigned CNT_W = $clog2(MAX_OUTST) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTST);

    typedef enum logic {
        OWNER_INST = 1'b0,
        OWNER_DATA = 1'b1
    } owner_e;

    logic             lock_valid_q, lock_valid_d;
    owner_e           lock_id_q, lock_id_d;
    owner_e           tags_q [MAX_OUTST];
    owner_e           tags_d [MAX_OUTST];
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

    owner_e grant;
    owner_e head;
    logic   grant_req;
    logic   full;
    logic   accept;
    logic   pop;

    // A pending (offered but not accepted) request keeps the port until it is taken or withdrawn.
    always_comb begin
        grant = OWNER_INST;
        if (lock_valid_q) begin
            grant = lock_id_q;
        end else if (data_req) begin
            grant = OWNER_DATA;
        end
        grant_req    = (grant == OWNER_DATA) ? data_req : inst_req;
        full         = (count_q == FULL_CNT);
        mem_req      = grant_req & ~full;
        accept       = mem_req & mem_addr_ok;
        inst_addr_ok = accept & (grant == OWNER_INST);
        data_addr_ok = accept & (grant == OWNER_DATA);
    end

    always_comb begin
        mem_wr    = 1'b0;
        mem_size  = 2'b10;
        mem_wstrb = '0;
        mem_addr  = inst_addr;
        mem_wdata = '0;
        if (grant == OWNER_DATA) begin
            mem_wr    = data_wr;
            mem_size  = data_size;
            mem_wstrb = data_wstrb;
            mem_addr  = data_addr;
            mem_wdata = data_wdata;
        end
    end

    // Responses arriving with nothing outstanding are dropped without touching state.
    always_comb begin
        head         = tags_q[rd_ptr_q];
        pop          = mem_data_ok & (count_q != '0);
        inst_data_ok = pop & (head == OWNER_INST);
        data_data_ok = pop & (head == OWNER_DATA);
        inst_rdata   = mem_rdata;
        data_rdata   = mem_rdata;
    end

    always_comb begin
        lock_valid_d = mem_req & ~mem_addr_ok;
        lock_id_d    = lock_valid_d ? grant : lock_id_q;
        tags_d       = tags_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;

        if (accept) begin
            tags_d[wr_ptr_q] = grant;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({accept, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_valid_q <= 1'b0;
            lock_id_q    <= OWNER_INST;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            for (int unsigned i = 0; i < MAX_OUTST; i++) begin
                tags_q[i] <= OWNER_INST;
            end
        end else begin
            lock_valid_q <= lock_valid_d;
            lock_id_q    <= lock_id_d;
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            tags_q       <= tags_d;
        end
    end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Bench for sram_req_arbiter: directed protocol scenarios plus a randomized run
// against an owner-queue reference model.
module tb_sram_req_arbiter;

    localparam int unsigned MAXO = 2;

    logic        clk;
    logic        reset;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    // {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}
    logic [4:0]  flags;
    logic [70:0] fields;
    assign flags  = {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok};
    assign fields = {mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata};

    int n_cmp = 0;
    int n_bad = 0;

    sram_req_arbiter #(.MAX_OUTST(MAXO)) dut (
        .clk          (clk),
        .reset        (reset),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_size     (mem_size),
        .mem_wstrb    (mem_wstrb),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_addr_ok  (mem_addr_ok),
        .mem_data_ok  (mem_data_ok),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        inst_req    = 1'b0;
        inst_addr   = '0;
        data_req    = 1'b0;
        data_wr     = 1'b0;
        data_size   = 2'b10;
        data_wstrb  = '0;
        data_addr   = '0;
        data_wdata  = '0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        mem_rdata   = '0;
    endtask

    // Leaves the bench just after a falling edge with reset released.
    task automatic apply_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        n_cmp++;
        if (flags !== 5'b00000) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want %b", flags, 5'b00000);
        end
        @(negedge clk);
        mem_data_ok = 1'b1;
        #1;
        n_cmp++;
        if (flags !== 5'b00000) begin
            n_bad++;
            $display("FAIL reset_stray_rsp: got %b want %b", flags, 5'b00000);
        end
        @(negedge clk);
        mem_data_ok = 1'b0;
    endtask

    task automatic test_inst_fetch();
        apply_reset();
        inst_req    = 1'b1;
        inst_addr   = 32'h1C00_0000;
        mem_addr_ok = 1'b1;
        #1;
        n_cmp++;
        if (flags !== 5'b11000) begin
            n_bad++;
            $display("FAIL fetch_c0_flags: got %b want %b", flags, 5'b11000);
        end
        n_cmp++;
        if (fields !== {1'b0, 2'b10, 4'b0000, 32'h1C00_0000, 32'h0}) begin
            n_bad++;
            $display("FAIL fetch_c0_fields: got %h want %h", fields,
                     {1'b0, 2'b10, 4'b0000, 32'h1C00_0000, 32'h0});
        end
        @(negedge clk);
        inst_req    = 1'b0;
        mem_addr_ok = 1'b0;
        #1;
        n_cmp++;
        if (flags !== 5'b00000) begin
            n_bad++;
            $display("FAIL fetch_c1_flags: got %b want %b", flags, 5'b00000);
        end
        @(negedge clk);
        mem_data_ok = 1'b1;
        mem_rdata   = 32'h0280_0C0C;
        #1;
        n_cmp++;
        if (flags !== 5'b00010 || inst_rdata !== 32'h0280_0C0C) begin
            n_bad++;
            $display("FAIL fetch_c2_rsp: got %b/%h want %b/%h", flags, inst_rdata,
                     5'b00010, 32'h0280_0C0C);
        end
        @(negedge clk);
        mem_data_ok = 1'b0;
    endtask

    task automatic test_priority();
        apply_reset();
        inst_req    = 1'b1;
        inst_addr   = 32'h1C00_0040;
        data_req    = 1'b1;
        data_addr   = 32'h0000_8000;
        mem_addr_ok = 1'b1;
        #1;
        n_cmp++;
        if (flags !== 5'b10100 || mem_addr !== 32'h0000_8000) begin
            n_bad++;
            $display("FAIL prio_n: got %b/%h want %b/%h", flags, mem_addr, 5'b10100, 32'h0000_8000);
        end
        @(negedge clk);
        data_req = 1'b0;
        #1;
        n_cmp++;
        if (flags !== 5'b11000 || mem_addr !== 32'h1C00_0040) begin
            n_bad++;
            $display("FAIL prio_n1: got %b/%h want %b/%h", flags, mem_addr, 5'b11000, 32'h1C00_0040);
        end
        @(negedge clk);
        inst_req    = 1'b0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        mem_rdata   = 32'hDEAD_0001;
        #1;
        n_cmp++;
        if (flags !== 5'b00001 || data_rdata !== 32'hDEAD_0001) begin
            n_bad++;
            $display("FAIL prio_rsp1: got %b/%h want %b/%h", flags, data_rdata, 5'b00001, 32'hDEAD_0001);
        end
        @(negedge clk);
        mem_rdata = 32'hBEEF_0002;
        #1;
        n_cmp++;
        if (flags !== 5'b00010 || inst_rdata !== 32'hBEEF_0002) begin
            n_bad++;
            $display("FAIL prio_rsp2: got %b/%h want %b/%h", flags, inst_rdata, 5'b00010, 32'hBEEF_0002);
        end
        @(negedge clk);
        mem_data_ok = 1'b0;
    endtask

    task automatic test_lock();
        apply_reset();
        inst_req  = 1'b1;
        inst_addr = 32'h1C00_0100;
        data_addr = 32'h0000_0200;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) begin
                @(negedge clk);
                data_req = 1'b1;
            end
            #1;
            n_cmp++;
            if (flags !== 5'b10000 || mem_addr !== 32'h1C00_0100) begin
                n_bad++;
                $display("FAIL lock_c%0d: got %b/%h want %b/%h", c, flags, mem_addr,
                         5'b10000, 32'h1C00_0100);
            end
        end
        @(negedge clk);
        mem_addr_ok = 1'b1;
        #1;
        n_cmp++;
        if (flags !== 5'b11000 || mem_addr !== 32'h1C00_0100) begin
            n_bad++;
            $display("FAIL lock_c3: got %b/%h want %b/%h", flags, mem_addr, 5'b11000, 32'h1C00_0100);
        end
        @(negedge clk);
        inst_req = 1'b0;
        #1;
        n_cmp++;
        if (flags !== 5'b10100 || mem_addr !== 32'h0000_0200) begin
            n_bad++;
            $display("FAIL lock_c4: got %b/%h want %b/%h", flags, mem_addr, 5'b10100, 32'h0000_0200);
        end
        @(negedge clk);
        data_req    = 1'b0;
        mem_addr_ok = 1'b0;
    endtask

    task automatic test_full();
        logic [4:0] exp_f [7];
        exp_f = '{5'b11000, 5'b10100, 5'b00000, 5'b00010, 5'b11000, 5'b00001, 5'b00010};
        apply_reset();
        for (int c = 0; c < 7; c++) begin
            if (c > 0) @(negedge clk);
            inst_req    = (c == 0 || c == 2 || c == 3 || c == 4);
            data_req    = (c == 1);
            mem_addr_ok = (c <= 4);
            mem_data_ok = (c == 3 || c == 5 || c == 6);
            #1;
            n_cmp++;
            if (flags !== exp_f[c]) begin
                n_bad++;
                $display("FAIL full_c%0d: got %b want %b", c, flags, exp_f[c]);
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_store();
        apply_reset();
        data_req    = 1'b1;
        data_wr     = 1'b1;
        data_size   = 2'b00;
        data_wstrb  = 4'b0100;
        data_addr   = 32'h0000_0102;
        data_wdata  = 32'h00AB_0000;
        mem_addr_ok = 1'b1;
        #1;
        n_cmp++;
        if (flags !== 5'b10100) begin
            n_bad++;
            $display("FAIL store_flags: got %b want %b", flags, 5'b10100);
        end
        n_cmp++;
        if (fields !== {1'b1, 2'b00, 4'b0100, 32'h0000_0102, 32'h00AB_0000}) begin
            n_bad++;
            $display("FAIL store_fields: got %h want %h", fields,
                     {1'b1, 2'b00, 4'b0100, 32'h0000_0102, 32'h00AB_0000});
        end
        @(negedge clk);
        data_req    = 1'b0;
        data_wr     = 1'b0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        #1;
        n_cmp++;
        if (flags !== 5'b00001) begin
            n_bad++;
            $display("FAIL store_ack: got %b want %b", flags, 5'b00001);
        end
        @(negedge clk);
        mem_data_ok = 1'b0;
    endtask

    task automatic test_reset_midflight();
        apply_reset();
        data_req    = 1'b1;
        mem_addr_ok = 1'b1;
        @(negedge clk);
        data_req = 1'b0;
        inst_req = 1'b1;
        @(negedge clk);
        inst_req    = 1'b0;
        mem_addr_ok = 1'b0;
        reset       = 1'b1;
        @(negedge clk);
        reset       = 1'b0;
        mem_data_ok = 1'b1;
        #1;
        n_cmp++;
        if (flags !== 5'b00000) begin
            n_bad++;
            $display("FAIL midrst_stray: got %b want %b", flags, 5'b00000);
        end
        @(negedge clk);
        mem_data_ok = 1'b0;
        inst_req    = 1'b1;
        mem_addr_ok = 1'b1;
        #1;
        n_cmp++;
        if (flags !== 5'b11000) begin
            n_bad++;
            $display("FAIL midrst_accept: got %b want %b", flags, 5'b11000);
        end
        @(negedge clk);
        inst_req    = 1'b0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        #1;
        n_cmp++;
        if (flags !== 5'b00010) begin
            n_bad++;
            $display("FAIL midrst_rsp: got %b want %b", flags, 5'b00010);
        end
        @(negedge clk);
        mem_data_ok = 1'b0;
    endtask

    // Reference: queue of owners in acceptance order, plus whoever holds an unaccepted offer.
    task automatic test_random();
        bit          owners [$];
        bit          pend_v;
        bit          pend_o;
        bit          owner;
        bit          oreq;
        bit          head;
        bit          e_mreq;
        bit          e_acc;
        bit          e_pop;
        logic [4:0]  e_flags;
        logic [70:0] e_fields;
        logic [31:0] got_rdata;
        apply_reset();
        pend_v = 1'b0;
        pend_o = 1'b0;
        for (int c = 0; c < 800; c++) begin
            reset       = ($urandom_range(0, 99) < 2);
            inst_req    = ($urandom_range(0, 9) < 6);
            inst_addr   = $urandom;
            data_req    = 1'($urandom_range(0, 1));
            data_wr     = 1'($urandom_range(0, 1));
            data_size   = 2'($urandom_range(0, 2));
            data_wstrb  = 4'($urandom_range(0, 15));
            data_addr   = $urandom;
            data_wdata  = $urandom;
            mem_addr_ok = 1'($urandom_range(0, 1));
            mem_data_ok = ($urandom_range(0, 9) < 4);
            mem_rdata   = $urandom;
            #1;
            owner   = pend_v ? pend_o : data_req;
            oreq    = owner ? data_req : inst_req;
            e_mreq  = oreq && (owners.size() < MAXO);
            e_acc   = e_mreq && mem_addr_ok;
            e_pop   = mem_data_ok && (owners.size() > 0);
            head    = (owners.size() > 0) ? owners[0] : 1'b0;
            e_flags = {e_mreq, e_acc && !owner, e_acc && owner, e_pop && !head, e_pop && head};
            n_cmp++;
            if (flags !== e_flags) begin
                n_bad++;
                $display("FAIL rand_flags c%0d: got %b want %b", c, flags, e_flags);
            end
            if (e_mreq) begin
                e_fields = owner ? {data_wr, data_size, data_wstrb, data_addr, data_wdata}
                                 : {1'b0, 2'b10, 4'b0000, inst_addr, 32'h0};
                n_cmp++;
                if (fields !== e_fields) begin
                    n_bad++;
                    $display("FAIL rand_fields c%0d: got %h want %h", c, fields, e_fields);
                end
            end
            if (e_pop) begin
                got_rdata = head ? data_rdata : inst_rdata;
                n_cmp++;
                if (got_rdata !== mem_rdata) begin
                    n_bad++;
                    $display("FAIL rand_rdata c%0d: got %h want %h", c, got_rdata, mem_rdata);
                end
            end
            @(posedge clk);
            if (reset) begin
                owners.delete();
                pend_v = 1'b0;
            end else begin
                if (e_pop) void'(owners.pop_front());
                if (e_acc) owners.push_back(owner);
                pend_v = e_mreq && !mem_addr_ok;
                pend_o = owner;
            end
            @(negedge clk);
        end
        reset = 1'b0;
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_inst_fetch();
        test_priority();
        test_lock();
        test_full();
        test_store();
        test_reset_midflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

endmodule
